// File: rtl/instruction_pair_buffer.sv
// Fetch-side instruction queue: issues sequential word fetches, buffers returned words with
// their PCs and presents the oldest two entries to the dual-issue scheduler.
module instruction_pair_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        freeze1,
    input  logic        freeze2,
    output logic [31:0] instruction0,
    output logic [31:0] instruction1,
    output logic [31:0] pc0,
    output logic [31:0] pc1,
    output logic        nothing_filled
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            discard_q, discard_d;

    logic            accept;
    logic            push;
    logic            pop;
    logic [CntW-1:0] pop_n;
    logic [CntW-1:0] occupancy;
    logic [PtrW-1:0] head_next_slot;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outstanding response counts against capacity so an accepted word always has a slot.
    assign occupancy = count_q + CntW'(inflight_q);
    assign imem_req  = rst_n && !redirect_valid && (occupancy < DepthCnt);
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A response is only legitimate in the cycle after an accepted request.
    assign push = imem_rvalid && inflight_q && !discard_q && !redirect_valid;
    assign pop  = !freeze1 && !freeze2 && (count_q != '0) && !redirect_valid;

    always_comb begin
        pop_n = '0;
        if (pop) begin
            pop_n = (count_q >= CntW'(2)) ? CntW'(2) : count_q;
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        discard_d  = 1'b0;
        if (redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            discard_d  = inflight_q;
        end else begin
            head_d  = head_q + pop_n[PtrW-1:0];
            tail_d  = tail_q + PtrW'(push);
            count_d = count_q + CntW'(push) - pop_n;
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]    <= req_pc_q;
        end
    end

    assign head_next_slot = head_q + PtrW'(1);

    // Empty slots read as zero so the scheduler can disable that lane.
    always_comb begin
        instruction0 = '0;
        pc0          = '0;
        instruction1 = '0;
        pc1          = '0;
        if (count_q != '0) begin
            instruction0 = instr_mem[head_q];
            pc0          = pc_mem[head_q];
        end
        if (count_q >= CntW'(2)) begin
            instruction1 = instr_mem[head_next_slot];
            pc1          = pc_mem[head_next_slot];
        end
    end

    assign nothing_filled = (count_q == '0);

    assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == DepthCnt)))
        else $error("instruction_pair_buffer: push into full queue");

endmodule

// File: tb/tb_instruction_pair_buffer.sv
// Bench for instruction_pair_buffer: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model.
module tb_instruction_pair_buffer;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        freeze1;
    logic        freeze2;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        nothing_filled;

    instruction_pair_buffer #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .freeze1       (freeze1),
        .freeze2       (freeze2),
        .instruction0  (instruction0),
        .instruction1  (instruction1),
        .pc0           (pc0),
        .pc1           (pc1),
        .nothing_filled(nothing_filled)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: queue of {instr, pc}, oldest at index 0.
    logic [63:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_reqpc;
    bit          m_inflight;
    bit          m_discard;
    bit          word_const;
    logic [31:0] const_word;
    bit          spurious_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc      = RESET_PC;
        m_reqpc    = RESET_PC;
        m_inflight = 0;
        m_discard  = 0;
    endtask

    // One cycle: drive memory response, check all outputs, advance the model, cross the edge.
    task automatic step();
        bit          e_req;
        bit          push;
        logic [31:0] e_i0, e_i1, e_p0, e_p1;
        if (rst_n && m_inflight) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_const ? const_word : m_reqpc + 32'h100;
        end else begin
            imem_rvalid = spurious_rv;
            imem_rdata  = 32'hdead_beef;
        end
        #1;
        e_req = rst_n && !redirect_valid && ((mq.size() + int'(m_inflight)) < int'(DEPTH));
        e_i0  = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
        e_p0  = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
        e_i1  = (mq.size() > 1) ? mq[1][63:32] : 32'h0;
        e_p1  = (mq.size() > 1) ? mq[1][31:0]  : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("imem_addr", imem_addr, m_fpc);
        chk("instruction0", instruction0, e_i0);
        chk("pc0", pc0, e_p0);
        chk("instruction1", instruction1, e_i1);
        chk("pc1", pc1, e_p1);
        chk("nothing_filled", 32'(nothing_filled), 32'(mq.size() == 0));
        if (rst_n) begin
            push = imem_rvalid && m_inflight && !m_discard && !redirect_valid;
            if (redirect_valid) begin
                mq.delete();
                m_fpc      = {redirect_pc[31:2], 2'b00};
                m_discard  = m_inflight;
                m_inflight = 0;
            end else begin
                if (!freeze1 && !freeze2) begin
                    repeat (2) if (mq.size() > 0) void'(mq.pop_front());
                end
                if (push) mq.push_back({imem_rdata, m_reqpc});
                m_discard = 0;
                if (e_req && imem_ready) begin
                    m_reqpc    = m_fpc;
                    m_fpc      = m_fpc + 32'd4;
                    m_inflight = 1;
                end else begin
                    m_inflight = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        freeze1        = 1'b0;
        freeze2        = 1'b0;
        word_const     = 0;
        const_word     = '0;
        spurious_rv    = 1;
        model_reset();

        // Reset held with stray rvalid
        repeat (2) step();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_nothing_filled", 32'(nothing_filled), 32'h1);

        // First pair after reset, freeze held so both words accumulate
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        freeze1    = 1'b1;
        step();
        spurious_rv = 0;
        repeat (2) step();
        chk("first_i0", instruction0, 32'h100);
        chk("first_pc0", pc0, 32'h0);
        chk("first_i1", instruction1, 32'h104);
        chk("first_pc1", pc1, 32'h4);

        // Continuous streaming
        freeze1 = 1'b0;
        repeat (10) step();

        // Fill to full and drain
        freeze1 = 1'b1;
        repeat (14) step();
        chk("full_req_low", 32'(imem_req), 32'h0);
        chk("full_not_empty", 32'(nothing_filled), 32'h0);
        freeze1 = 1'b0;
        repeat (6) step();

        // Wrap-around with alternating freeze
        repeat (30) begin
            freeze2 = ~freeze2;
            step();
        end
        freeze2 = 1'b0;

        // Single entry
        freeze1        = 1'b1;
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0303;
        step();
        redirect_valid = 1'b0;
        word_const     = 1;
        const_word     = 32'h13;
        imem_ready     = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        chk("single_i0", instruction0, 32'h13);
        chk("single_pc0", pc0, 32'h300);
        chk("single_i1", instruction1, 32'h0);
        chk("single_nf", 32'(nothing_filled), 32'h0);
        freeze1 = 1'b0;
        step();
        chk("single_popped_nf", 32'(nothing_filled), 32'h1);
        word_const = 0;

        // Redirect while a response is in flight
        freeze1        = 1'b1;
        imem_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("redir_dropped_nf", 32'(nothing_filled), 32'h1);
        step();
        chk("redir_still_empty", 32'(nothing_filled), 32'h1);
        step();
        chk("redir_pc0", pc0, 32'h200);
        chk("redir_i0", instruction0, 32'h300);

        // Random traffic
        repeat (400) begin
            imem_ready     = ($urandom_range(0, 3) != 0);
            freeze1        = ($urandom_range(0, 3) == 0);
            freeze2        = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            step();
        end

        // Async reset mid-burst at count 5
        freeze1        = 1'b1;
        freeze2        = 1'b0;
        imem_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 20 && mq.size() != 5; k++) step();
        chk("burst_pc0", pc0, 32'h1000);
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_i0", instruction0, 32'h0);
        chk("async_pc1", pc1, 32'h0);
        chk("async_nf", 32'(nothing_filled), 32'h1);
        model_reset();
        spurious_rv = 1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        spurious_rv = 0;
        repeat (6) step();
        chk("resume_pc0", pc0, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
